fuel_station_feeder: RTL and testbench
======================================

FUEL_STATION_FEEDER -- requirements
Module: fuel_station_feeder

Interface
REQ-001 SHALL have ports (clock and reset first):
 CLK  in  1  system clock; all state updates on rising edge.
 RST_N  in  1  asynchronous, active-low reset.
 start  in  1  one-cycle pulse; begins a setup run.
 cfg_gas_pumps  in  3  gasoline pump count to program.
 cfg_diesel_pumps  in  3  diesel pump count to program.
 req_valid  in  1  car request offered.
 req_ready  out  1  request accepted this cycle when high with req_valid.
 req_type  in  1  0 = gasoline, 1 = diesel.
 req_amount  in  4  requested fuel units.
 mode  out  2  station mode: 2'b10 setup, 2'b01 car entrance, 2'b00 simulation.
 n_gasoline_pumps / n_diesel_pumps  out  3 each  setup values driven to the station.
 fuel_amount  out  4, fuel_type  out  1  car fields driven to the station.
 is_gasoline_queue_not_full / is_diesel_queue_not_full  in  1 each  station queue flags.
 invalid_gasoline_car / invalid_diesel_car / invalid_setup_params  in  1 each  station error flags.
 busy  out  1  high in every state except IDLE and ERROR.
 setup_error  out  1  station rejected the setup parameters.
 cars_sent  out  8  count of cars accepted by the station.
 cars_rejected  out  8  count of cars rejected, locally or by the station.
REQ-002 SHALL use one clock, CLK; reset SHALL be asynchronous and active-low on RST_N.

Function
REQ-003 Request FIFO SHALL be 4 entries, each holding {type, amount}; req_ready = not full; no bypass, so when full a pop does not make req_ready high in the same cycle.
REQ-004 FSM states SHALL be IDLE, SETUP, SETUP_CHK, RUN, ISSUE, CHECK, ERROR.
REQ-005 IDLE: mode=00; on start go to SETUP, clear counters and setup_error, flush FIFO.
REQ-006 SETUP, one cycle: mode=10, drive cfg_* on n_*_pumps; next state SETUP_CHK.
REQ-007 SETUP_CHK: mode=00; if invalid_setup_params=1, set setup_error and go to ERROR, else go to RUN.
REQ-008 RUN: mode=00; if the FIFO is non-empty and the head's queue flag is 1 this cycle, go to ISSUE; otherwise stay (head-of-line blocking, no reordering).
REQ-009 ISSUE, one cycle: mode=01, fuel_type and fuel_amount = head; next state CHECK.
REQ-010 CHECK: mode=00; sample the invalid flag matching the head type; on 1 increment cars_rejected, on 0 increment cars_sent; pop head; return to RUN.
REQ-011 Latency from FIFO head becoming eligible in RUN to mode=01 SHALL be exactly 1 cycle; minimum spacing between issues SHALL be 3 cycles.
REQ-012 Counters SHALL saturate at 255.
REQ-013 ERROR: mode=00, FIFO accepts but never issues; start returns to SETUP per REQ-005.
REQ-014 start outside IDLE/ERROR SHALL be ignored.
REQ-015 Outputs n_*_pumps, fuel_type and fuel_amount SHALL hold their last driven value when not in use.
REQ-016 A push and a pop in the same cycle SHALL leave the occupancy unchanged and both entries correct.

Reset
REQ-017 RST_N low SHALL immediately force: state IDLE, mode=00, n_*_pumps=0, fuel_amount=0, fuel_type=0, req_ready=1, busy=0, setup_error=0, counters=0, FIFO empty.
REQ-018 Reset asserted mid-ISSUE or mid-CHECK SHALL discard the in-flight car without counting it.

Configuration
REQ-019 With FEEDER_PRECHECK_EN defined: in RUN, a head with req_amount=0 or >8 SHALL be popped without issue, cars_rejected+1, 1 cycle.
REQ-020 Without FEEDER_PRECHECK_EN: every entry SHALL be issued, and only station flags determine rejection.

Verification
REQ-021 Reset, then start with cfg 0/1, invalid_setup_params=0 -> mode 10 for 1 cycle, then RUN, busy=1, setup_error=0.
REQ-022 Start with cfg 4/3 and invalid_setup_params=1 in SETUP_CHK -> setup_error=1, ERROR, busy=0, no mode=01.
REQ-023 Push diesel amounts 6, 1 and 3 with the diesel flag at 1 and invalid flags at 0 -> three mode=01 pulses 3 cycles apart with amounts 6, 1, 3; cars_sent=3.
REQ-024 Gasoline head with the gasoline flag at 0 and a diesel entry behind it -> nothing issued; setting the flag to 1 issues the gasoline car first.
REQ-025 Push 5 requests back-to-back with no pops -> req_ready=0 after 4; the fifth is accepted only after the first CHECK.
REQ-026 With FEEDER_PRECHECK_EN, push amount 9 -> no mode=01, cars_rejected=1; without it -> issued, and invalid_gasoline_car=1 gives cars_rejected=1.

Source files
------------

// File: rtl/fuel_station_feeder.sv
// fuel_station_feeder: buffers car requests in a 4-entry FIFO and feeds them
// to the fuel station one at a time. A setup run programs the pump counts
// first. Entries are issued strictly in order (head-of-line blocking), and
// cars the station accepts or rejects are counted.
// Optional feature: define FEEDER_PRECHECK_EN to drop heads whose amount is 0
// or greater than 8 locally, without issuing them.
module fuel_station_feeder (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       start,
  input  logic [2:0] cfg_gas_pumps,
  input  logic [2:0] cfg_diesel_pumps,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_type,
  input  logic [3:0] req_amount,
  output logic [1:0] mode,
  output logic [2:0] n_gasoline_pumps,
  output logic [2:0] n_diesel_pumps,
  output logic [3:0] fuel_amount,
  output logic       fuel_type,
  input  logic       is_gasoline_queue_not_full,
  input  logic       is_diesel_queue_not_full,
  input  logic       invalid_gasoline_car,
  input  logic       invalid_diesel_car,
  input  logic       invalid_setup_params,
  output logic       busy,
  output logic       setup_error,
  output logic [7:0] cars_sent,
  output logic [7:0] cars_rejected
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SETUP     = 3'd1,
    S_SETUP_CHK = 3'd2,
    S_RUN       = 3'd3,
    S_ISSUE     = 3'd4,
    S_CHECK     = 3'd5,
    S_ERROR     = 3'd6
  } state_e;

  state_e     state_q;
  logic [1:0] mode_q;
  logic       busy_q;
  logic       setup_error_q;
  logic [2:0] n_gas_q;
  logic [2:0] n_diesel_q;
  logic [3:0] fuel_amount_q;
  logic       fuel_type_q;
  logic [7:0] sent_q;
  logic [7:0] rejected_q;

  // FIFO storage: each entry is {type, amount}
  logic [4:0] mem_q [4];
  logic [1:0] wr_ptr_q;
  logic [1:0] rd_ptr_q;
  logic [2:0] count_q;

  logic       fifo_empty;
  logic       flush;
  logic       push;
  logic       pop;
  logic       head_type;
  logic [3:0] head_amount;
  logic       head_eligible;
  logic       head_invalid;
  logic       precheck_drop;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign fifo_empty    = (count_q == 3'd0);
  assign req_ready     = (count_q != 3'd4);
  assign head_type     = mem_q[rd_ptr_q][4];
  assign head_amount   = mem_q[rd_ptr_q][3:0];
  assign head_eligible = head_type ? is_diesel_queue_not_full : is_gasoline_queue_not_full;
  assign head_invalid  = head_type ? invalid_diesel_car : invalid_gasoline_car;
  assign flush         = start && ((state_q == S_IDLE) || (state_q == S_ERROR));
  assign push          = req_valid && req_ready && !flush;

`ifdef FEEDER_PRECHECK_EN
  assign precheck_drop = (state_q == S_RUN) && !fifo_empty &&
                         ((head_amount == 4'd0) || (head_amount > 4'd8));
`else
  assign precheck_drop = 1'b0;
`endif

  // The head leaves the FIFO after its station verdict, or when dropped locally
  assign pop = (state_q == S_CHECK) || precheck_drop;

  // FIFO pointers, occupancy and storage; a start from IDLE/ERROR flushes it
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
      for (int i = 0; i < 4; i++) mem_q[i] <= 5'd0;
    end else if (flush) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {req_type, req_amount};
        wr_ptr_q        <= wr_ptr_q + 2'd1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 2'd1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Control FSM with all station-facing outputs registered alongside the state
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= S_IDLE;
      mode_q        <= 2'b00;
      busy_q        <= 1'b0;
      setup_error_q <= 1'b0;
      n_gas_q       <= 3'd0;
      n_diesel_q    <= 3'd0;
      fuel_amount_q <= 4'd0;
      fuel_type_q   <= 1'b0;
      sent_q        <= 8'd0;
      rejected_q    <= 8'd0;
    end else begin
      case (state_q)
        S_IDLE, S_ERROR: begin
          if (start) begin
            state_q       <= S_SETUP;
            mode_q        <= 2'b10;
            busy_q        <= 1'b1;
            setup_error_q <= 1'b0;
            n_gas_q       <= cfg_gas_pumps;
            n_diesel_q    <= cfg_diesel_pumps;
            sent_q        <= 8'd0;
            rejected_q    <= 8'd0;
          end
        end
        S_SETUP: begin
          state_q <= S_SETUP_CHK;
          mode_q  <= 2'b00;
        end
        S_SETUP_CHK: begin
          if (invalid_setup_params) begin
            state_q       <= S_ERROR;
            setup_error_q <= 1'b1;
            busy_q        <= 1'b0;
          end else begin
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (precheck_drop) begin
            rejected_q <= sat_inc(rejected_q);
          end else if (!fifo_empty && head_eligible) begin
            state_q       <= S_ISSUE;
            mode_q        <= 2'b01;
            fuel_type_q   <= head_type;
            fuel_amount_q <= head_amount;
          end
        end
        S_ISSUE: begin
          state_q <= S_CHECK;
          mode_q  <= 2'b00;
        end
        S_CHECK: begin
          if (head_invalid) begin
            rejected_q <= sat_inc(rejected_q);
          end else begin
            sent_q <= sat_inc(sent_q);
          end
          state_q <= S_RUN;
        end
        default: begin
          state_q <= S_IDLE;
          mode_q  <= 2'b00;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mode             = mode_q;
  assign busy             = busy_q;
  assign setup_error      = setup_error_q;
  assign n_gasoline_pumps = n_gas_q;
  assign n_diesel_pumps   = n_diesel_q;
  assign fuel_amount      = fuel_amount_q;
  assign fuel_type        = fuel_type_q;
  assign cars_sent        = sent_q;
  assign cars_rejected    = rejected_q;

endmodule

// File: tb/tb_fuel_station_feeder.sv
// Randomized bench for fuel_station_feeder. A transaction-level model holds
// the waiting cars in a queue, the car at the station in a separate slot,
// and the counters as plain integers.
module tb_fuel_station_feeder;

  logic       CLK;
  logic       RST_N;
  logic       start;
  logic [2:0] cfg_gas_pumps;
  logic [2:0] cfg_diesel_pumps;
  logic       req_valid;
  logic       req_ready;
  logic       req_type;
  logic [3:0] req_amount;
  logic [1:0] mode;
  logic [2:0] n_gasoline_pumps;
  logic [2:0] n_diesel_pumps;
  logic [3:0] fuel_amount;
  logic       fuel_type;
  logic       is_gasoline_queue_not_full;
  logic       is_diesel_queue_not_full;
  logic       invalid_gasoline_car;
  logic       invalid_diesel_car;
  logic       invalid_setup_params;
  logic       busy;
  logic       setup_error;
  logic [7:0] cars_sent;
  logic [7:0] cars_rejected;

  fuel_station_feeder dut (
    .CLK                        (CLK),
    .RST_N                      (RST_N),
    .start                      (start),
    .cfg_gas_pumps              (cfg_gas_pumps),
    .cfg_diesel_pumps           (cfg_diesel_pumps),
    .req_valid                  (req_valid),
    .req_ready                  (req_ready),
    .req_type                   (req_type),
    .req_amount                 (req_amount),
    .mode                       (mode),
    .n_gasoline_pumps           (n_gasoline_pumps),
    .n_diesel_pumps             (n_diesel_pumps),
    .fuel_amount                (fuel_amount),
    .fuel_type                  (fuel_type),
    .is_gasoline_queue_not_full (is_gasoline_queue_not_full),
    .is_diesel_queue_not_full   (is_diesel_queue_not_full),
    .invalid_gasoline_car       (invalid_gasoline_car),
    .invalid_diesel_car         (invalid_diesel_car),
    .invalid_setup_params       (invalid_setup_params),
    .busy                       (busy),
    .setup_error                (setup_error),
    .cars_sent                  (cars_sent),
    .cars_rejected              (cars_rejected)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    bit typ;
    int amt;
  } car_t;

  // Reference model
  car_t mq[$];        // cars waiting in the feeder, head first
  car_t at_station;   // car currently handed to the station
  int   stage;        // 0: none, 1: being offered (mode 01), 2: awaiting verdict
  bit   running;      // feeder is dispatching cars
  bit   err_flag;
  int   m_sent;
  int   m_rej;
  int   m_ftype;
  int   m_famt;
  int   m_ngas;
  int   m_ndsl;

  int vectors;
  int miscompares;
  int p_valid;
  int p_flag;
  int p_inv;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit locally_bad(input int amt);
`ifdef FEEDER_PRECHECK_EN
    return (amt == 0) || (amt > 8);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int occupancy();
    return mq.size() + ((stage != 0) ? 1 : 0);
  endfunction

  task automatic model_reset();
    mq.delete();
    stage    = 0;
    running  = 1'b0;
    err_flag = 1'b0;
    m_sent   = 0;
    m_rej    = 0;
    m_ftype  = 0;
    m_famt   = 0;
    m_ngas   = 0;
    m_ndsl   = 0;
  endtask

  task automatic compare_outputs();
    check("mode", mode, (stage == 1) ? 2'b01 : 2'b00);
    check("req_ready", req_ready, (occupancy() < 4) ? 1 : 0);
    check("busy", busy, running);
    check("setup_error", setup_error, err_flag);
    check("cars_sent", cars_sent, m_sent);
    check("cars_rejected", cars_rejected, m_rej);
    check("fuel_type", fuel_type, m_ftype);
    check("fuel_amount", fuel_amount, m_famt);
    check("n_gas", n_gasoline_pumps, m_ngas);
    check("n_diesel", n_diesel_pumps, m_ndsl);
  endtask

  task automatic drive_random();
    start                      = running ? ($urandom_range(0, 49) == 0) : 1'b0;
    req_valid                  = ($urandom_range(0, 99) < p_valid);
    req_type                   = $urandom_range(0, 1);
    req_amount                 = $urandom_range(0, 15);
    is_gasoline_queue_not_full = ($urandom_range(0, 99) < p_flag);
    is_diesel_queue_not_full   = ($urandom_range(0, 99) < p_flag);
    invalid_gasoline_car       = ($urandom_range(0, 99) < p_inv);
    invalid_diesel_car         = ($urandom_range(0, 99) < p_inv);
  endtask

  // Apply this cycle's inputs to the model, giving the next cycle's view
  task automatic model_advance();
    bit  accept;
    bit  flag;
    bit  inv;
    accept = req_valid && (occupancy() < 4);
    if (stage == 1) begin
      stage = 2;
    end else if (stage == 2) begin
      inv = at_station.typ ? invalid_diesel_car : invalid_gasoline_car;
      if (inv) m_rej  = (m_rej  < 255) ? m_rej  + 1 : 255;
      else     m_sent = (m_sent < 255) ? m_sent + 1 : 255;
      stage = 0;
    end else if (running && mq.size() > 0) begin
      flag = mq[0].typ ? is_diesel_queue_not_full : is_gasoline_queue_not_full;
      if (locally_bad(mq[0].amt)) begin
        void'(mq.pop_front());
        m_rej = (m_rej < 255) ? m_rej + 1 : 255;
      end else if (flag) begin
        at_station = mq.pop_front();
        stage      = 1;
        m_ftype    = at_station.typ;
        m_famt     = at_station.amt;
      end
    end
    if (accept) begin
      car_t c;
      c.typ = req_type;
      c.amt = req_amount;
      mq.push_back(c);
    end
  endtask

  task automatic run_random(input int n);
    for (int i = 0; i < n; i++) begin
      compare_outputs();
      drive_random();
      model_advance();
      @(negedge CLK);
    end
  endtask

  // Called at the sampling point of an IDLE or ERROR cycle
  task automatic do_setup(input int g, input int d, input bit inv);
    start                = 1'b1;
    cfg_gas_pumps        = g[2:0];
    cfg_diesel_pumps     = d[2:0];
    req_valid            = 1'b0;
    invalid_setup_params = 1'b0;
    @(negedge CLK);
    start = 1'b0;
    check("setup_mode", mode, 2'b10);
    check("setup_n_gas", n_gasoline_pumps, g);
    check("setup_n_diesel", n_diesel_pumps, d);
    check("setup_busy", busy, 1);
    check("setup_err_clr", setup_error, 0);
    check("setup_sent_clr", cars_sent, 0);
    check("setup_rej_clr", cars_rejected, 0);
    check("setup_flushed", req_ready, 1);
    invalid_setup_params = inv;
    @(negedge CLK);
    check("setupchk_mode", mode, 2'b00);
    check("setupchk_busy", busy, 1);
    @(negedge CLK);
    invalid_setup_params = 1'b0;
    check("post_setup_busy", busy, !inv);
    check("post_setup_err", setup_error, inv);
    check("post_setup_mode", mode, 2'b00);
    mq.delete();
    stage    = 0;
    running  = !inv;
    err_flag = inv;
    m_sent   = 0;
    m_rej    = 0;
    m_ngas   = g;
    m_ndsl   = d;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_mode"}, mode, 2'b00);
    check({tag, "_n_gas"}, n_gasoline_pumps, 0);
    check({tag, "_n_diesel"}, n_diesel_pumps, 0);
    check({tag, "_famt"}, fuel_amount, 0);
    check({tag, "_ftype"}, fuel_type, 0);
    check({tag, "_ready"}, req_ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err"}, setup_error, 0);
    check({tag, "_sent"}, cars_sent, 0);
    check({tag, "_rej"}, cars_rejected, 0);
  endtask

  initial begin
    int guard;
    vectors     = 0;
    miscompares = 0;
    RST_N                      = 1'b0;
    start                      = 1'b0;
    cfg_gas_pumps              = 3'd0;
    cfg_diesel_pumps           = 3'd0;
    req_valid                  = 1'b0;
    req_type                   = 1'b0;
    req_amount                 = 4'd0;
    is_gasoline_queue_not_full = 1'b0;
    is_diesel_queue_not_full   = 1'b0;
    invalid_gasoline_car       = 1'b0;
    invalid_diesel_car         = 1'b0;
    invalid_setup_params       = 1'b0;
    model_reset();

    repeat (2) @(negedge CLK);
    check_reset_values("reset");
    RST_N = 1'b1;
    @(negedge CLK);

    // Valid setup, then mixed traffic
    do_setup(0, 1, 1'b0);
    p_valid = 50; p_flag = 40; p_inv = 30;
    run_random(300);
    // Mostly blocked station: FIFO fills, head-of-line blocking
    p_valid = 80; p_flag = 5;
    run_random(150);
    // Heavy flow
    p_valid = 90; p_flag = 90; p_inv = 50;
    run_random(200);

    // Reset while a car is at the station
    guard = 0;
    while (stage != 1 && guard < 200) begin
      compare_outputs();
      drive_random();
      model_advance();
      @(negedge CLK);
      guard++;
    end
    check("inflight_reached", (stage == 1) ? 1 : 0, 1);
    RST_N = 1'b0;
    #1;
    model_reset();
    check_reset_values("midreset");
    @(negedge CLK);
    RST_N     = 1'b1;
    req_valid = 1'b0;
    @(negedge CLK);
    check_reset_values("after_reset");

    // Rejected setup: ERROR accepts cars but never issues
    do_setup(4, 3, 1'b1);
    p_valid = 60; p_flag = 100; p_inv = 0;
    run_random(60);

    // Restart from ERROR, then drive counters into saturation
    do_setup(2, 5, 1'b0);
    p_valid = 100; p_flag = 100; p_inv = 0;
    run_random(900);
    check("sent_saturated", cars_sent, 255);
    p_inv = 100;
    run_random(900);
    check("rej_saturated", cars_rejected, 255);
    p_valid = 60; p_flag = 50; p_inv = 40;
    run_random(200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
